// File: rtl/mem_read_streamer.sv
// Read-side master for a simple dual-port memory: issues sequential B-port reads, absorbs the
// fixed read latency and presents the words as a valid/ready/last stream.
// Optional abort input is enabled by defining MEM_RD_STREAMER_ABORT_EN.
module mem_read_streamer #(
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 1024,
  parameter int  OUTPUT_DELAY = 1,
  parameter int  FIFO_DEPTH   = 4,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef MEM_RD_STREAMER_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  inflight, inflight_nxt;
  logic [CNT_W-1:0]  fifo_count, count_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic              issue, issue_last, push, push_last, pop, drain_clear, abort_now;

`ifdef MEM_RD_STREAMER_ABORT_EN
  assign abort_now = abort && (state != S_IDLE);
`else
  assign abort_now = 1'b0;
`endif

  // Credit check: every issued word already owns a FIFO slot, so nothing can be dropped.
  assign issue      = (state == S_RUN) && (remaining != '0) &&
                      ((inflight + fifo_count) < CNT_W'(FIFO_DEPTH));
  assign issue_last = issue && (remaining == LEN_W'(1));
  assign mem_re     = issue;

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign {m_last, m_data} = m_valid ? fifo_mem[rd_ptr] : '0;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    inflight_nxt = inflight;
    count_nxt    = fifo_count;
    if (issue && !push)      inflight_nxt = inflight + CNT_W'(1);
    else if (!issue && push) inflight_nxt = inflight - CNT_W'(1);
    if (push && !pop)        count_nxt = fifo_count + CNT_W'(1);
    else if (!push && pop)   count_nxt = fifo_count - CNT_W'(1);
  end

  assign drain_clear = (inflight_nxt == '0) && (count_nxt == '0);

  // Issue/last flags travel alongside the memory pipeline so capture lines up with dob.
  generate
    if (OUTPUT_DELAY == 0) begin : g_no_delay
      assign push      = issue;
      assign push_last = issue_last;
    end else begin : g_delay
      logic [OUTPUT_DELAY-1:0] pipe_vld, pipe_last;
      always_ff @(posedge clk) begin
        if (rst || abort_now) begin
          pipe_vld  <= '0;
          pipe_last <= '0;
        end else begin
          pipe_vld[0]  <= issue;
          pipe_last[0] <= issue_last;
          for (int i = 1; i < OUTPUT_DELAY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_last[i] <= pipe_last[i-1];
          end
        end
      end
      assign push      = pipe_vld[OUTPUT_DELAY-1];
      assign push_last = pipe_last[OUTPUT_DELAY-1];
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        mem_addr  <= mem_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (abort_now) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (start_len == '0) begin
                done <= 1'b1;
              end else begin
                state     <= S_RUN;
                busy      <= 1'b1;
                mem_addr  <= start_addr;
                remaining <= start_len;
              end
            end
          end
          S_RUN: begin
            if (issue_last) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (drain_clear) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort_now) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_nxt;
      inflight   <= inflight_nxt;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {push_last, mem_dout};
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench for mem_read_streamer: three instances (read latency 0/1/2), each with a
// behavioural memory holding mem[i]=i; the latency-1 instance is the main one checked.
module tb_mem_read_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, m_ready;
  logic [9:0]  start_addr;
  logic [10:0] start_len;
`ifdef MEM_RD_STREAMER_ABORT_EN
  logic        abort;
`endif

  logic        busy, done, mem_re, m_valid, m_last;
  logic [9:0]  mem_addr;
  logic [31:0] mem_dout, m_data;
  logic        busy_d0, done_d0, re_d0, valid_d0, last_d0;
  logic [9:0]  addr_d0;
  logic [31:0] dout_d0, data_d0;
  logic        busy_d2, done_d2, re_d2, valid_d2, last_d2;
  logic [9:0]  addr_d2;
  logic [31:0] dout_d2, data_d2, d2_stage;

  // Memory models: combinational, one gated register, gated stage plus ungated stage.
  assign dout_d0 = {22'b0, addr_d0};
  always @(posedge clk) if (mem_re) mem_dout <= {22'b0, mem_addr};
  always @(posedge clk) begin
    if (re_d2) d2_stage <= {22'b0, addr_d2};
    dout_d2 <= d2_stage;
  end

  mem_read_streamer #(.DATA_WIDTH(32), .DEPTH(1024), .OUTPUT_DELAY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef MEM_RD_STREAMER_ABORT_EN
    , .abort(abort)
`endif
  );

  mem_read_streamer #(.DATA_WIDTH(32), .DEPTH(1024), .OUTPUT_DELAY(0), .FIFO_DEPTH(4)) dut_d0 (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy_d0), .done(done_d0), .mem_re(re_d0), .mem_addr(addr_d0), .mem_dout(dout_d0),
    .m_valid(valid_d0), .m_ready(m_ready), .m_data(data_d0), .m_last(last_d0)
`ifdef MEM_RD_STREAMER_ABORT_EN
    , .abort(abort)
`endif
  );

  mem_read_streamer #(.DATA_WIDTH(32), .DEPTH(1024), .OUTPUT_DELAY(2), .FIFO_DEPTH(4)) dut_d2 (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy_d2), .done(done_d2), .mem_re(re_d2), .mem_addr(addr_d2), .mem_dout(dout_d2),
    .m_valid(valid_d2), .m_ready(m_ready), .m_data(data_d2), .m_last(last_d2)
`ifdef MEM_RD_STREAMER_ABORT_EN
    , .abort(abort)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] beats[$];
  logic        lasts[$];
  int          re_cnt, re_first, re_last, done_cyc, fv, fv0, fv2, max_out;
  logic        addr_ok, done_busy, last0, last2;
  logic [31:0] dat0, dat2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Cycle 0 is the start cycle; records issues, beats and done of the latency-1 instance.
  task automatic run_xfer(input logic [9:0] addr, input logic [10:0] len, input int rdy_period,
                          input int poke_cyc, input int max_cyc);
    logic [9:0] exp_a;
    int issued, popped;
    exp_a = addr; issued = 0; popped = 0;
    beats.delete(); lasts.delete();
    re_cnt = 0; re_first = -1; re_last = -1; done_cyc = -1; fv = -1; fv0 = -1; fv2 = -1;
    max_out = 0; addr_ok = 1'b1; done_busy = 1'b0;
    @(negedge clk);
    for (int c = 0; c < max_cyc; c++) begin
      if (c == 0) begin
        start = 1'b1; start_addr = addr; start_len = len;
      end else begin
        start = (c == poke_cyc);
        if (start) begin start_addr = 10'h300; start_len = 11'd2; end
      end
      m_ready = (c % rdy_period) == 0;
      if (mem_re) begin
        if (mem_addr !== exp_a) addr_ok = 1'b0;
        exp_a = exp_a + 10'd1;
        re_cnt++;
        if (re_first < 0) re_first = c;
        re_last = c;
        issued++;
      end
      if (m_valid && fv < 0) fv = c;
      if (valid_d0 && fv0 < 0) begin fv0 = c; dat0 = data_d0; last0 = last_d0; end
      if (valid_d2 && fv2 < 0) begin fv2 = c; dat2 = data_d2; last2 = last_d2; end
      if (m_valid && m_ready) begin
        beats.push_back(m_data);
        lasts.push_back(m_last);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) begin done_cyc = c; done_busy = busy; break; end
      @(negedge clk);
    end
    start = 1'b0;
    m_ready = 1'b1;
    total++;
    if (done_cyc < 0) begin bad++; $display("FAIL timeout: no done within %0d cycles", max_cyc); end
  endtask

  task automatic idle(input int n, output int act);
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (mem_re || m_valid || busy || done) act++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, mem_re, m_valid, m_last} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_re, m_valid, m_last});
    end
    total++;
    if (mem_addr !== 10'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
    total++;
    if (m_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", m_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int act;
    run_xfer(10'h010, 11'd4, 1, -1, 40);
    total++; if (re_cnt !== 4) begin bad++; $display("FAIL basic_re_cnt: got %0d want 4", re_cnt); end
    total++; if (re_first !== 1) begin bad++; $display("FAIL basic_re_first: got %0d want 1", re_first); end
    total++; if (re_last !== 4) begin bad++; $display("FAIL basic_re_last: got %0d want 4", re_last); end
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL basic_addr_seq: got bad issue address want 010..013"); end
    total++; if (fv !== 3) begin bad++; $display("FAIL basic_first_valid: got %0d want 3", fv); end
    total++; if (beats.size() !== 4) begin bad++; $display("FAIL basic_beat_cnt: got %0d want 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] a;
      a = 10'h010 + 10'(i);
      total++;
      if (i >= beats.size()) begin bad++; $display("FAIL basic_beat%0d: got none want %h", i, {22'b0, a}); end
      else if (beats[i] !== {22'b0, a} || lasts[i] !== (i == 3)) begin
        bad++; $display("FAIL basic_beat%0d: got %h last=%b want %h last=%b", i, beats[i], lasts[i], {22'b0, a}, i == 3);
      end
    end
    total++; if (done_cyc !== 7) begin bad++; $display("FAIL basic_done_cyc: got %0d want 7", done_cyc); end
    total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", done_busy); end
    idle(3, act);
    total++; if (act !== 0) begin bad++; $display("FAIL basic_quiet_after: got %0d active cycles want 0", act); end
  endtask

  task automatic test_wrap();
    int act;
    run_xfer(10'h3FE, 11'd4, 1, -1, 40);
    total++; if (re_cnt !== 4 || addr_ok !== 1'b1) begin
      bad++; $display("FAIL wrap_issue: got cnt=%0d ok=%b want cnt=4 ok=1", re_cnt, addr_ok);
    end
    total++; if (beats.size() !== 4) begin bad++; $display("FAIL wrap_beat_cnt: got %0d want 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] a;
      a = 10'h3FE + 10'(i);
      total++;
      if (i >= beats.size()) begin bad++; $display("FAIL wrap_beat%0d: got none want %h", i, {22'b0, a}); end
      else if (beats[i] !== {22'b0, a} || lasts[i] !== (i == 3)) begin
        bad++; $display("FAIL wrap_beat%0d: got %h last=%b want %h last=%b", i, beats[i], lasts[i], {22'b0, a}, i == 3);
      end
    end
    idle(4, act);
  endtask

  task automatic test_backpressure();
    int act, nlast;
    run_xfer(10'h100, 11'd16, 3, -1, 200);
    total++; if (beats.size() !== 16) begin bad++; $display("FAIL bp_beat_cnt: got %0d want 16", beats.size()); end
    nlast = 0;
    for (int i = 0; i < 16; i++) begin
      logic [9:0] a;
      a = 10'h100 + 10'(i);
      total++;
      if (i >= beats.size()) begin bad++; $display("FAIL bp_beat%0d: got none want %h", i, {22'b0, a}); end
      else begin
        if (lasts[i]) nlast++;
        if (beats[i] !== {22'b0, a}) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, beats[i], {22'b0, a}); end
      end
    end
    total++; if (nlast !== 1 || lasts.size() != 16 || lasts[15] !== 1'b1) begin
      bad++; $display("FAIL bp_last: got %0d last flags want exactly one on beat 15", nlast);
    end
    total++; if (max_out > 4) begin bad++; $display("FAIL bp_outstanding: got %0d want <= 4", max_out); end
    total++; if (re_last - re_first + 1 <= 16) begin
      bad++; $display("FAIL bp_re_stall: got issue span %0d want > 16", re_last - re_first + 1);
    end
    total++; if (addr_ok !== 1'b1 || re_cnt !== 16) begin
      bad++; $display("FAIL bp_issue: got cnt=%0d ok=%b want cnt=16 ok=1", re_cnt, addr_ok);
    end
    idle(6, act);
  endtask

  task automatic test_latency();
    int act;
    run_xfer(10'h055, 11'd1, 1, -1, 20);
    total++; if (fv0 !== 2) begin bad++; $display("FAIL lat_d0: got %0d want 2", fv0); end
    total++; if (fv !== 3) begin bad++; $display("FAIL lat_d1: got %0d want 3", fv); end
    total++; if (fv2 !== 4) begin bad++; $display("FAIL lat_d2: got %0d want 4", fv2); end
    total++; if (dat0 !== 32'h55 || last0 !== 1'b1) begin
      bad++; $display("FAIL lat_d0_beat: got %h last=%b want 00000055 last=1", dat0, last0);
    end
    total++; if (dat2 !== 32'h55 || last2 !== 1'b1) begin
      bad++; $display("FAIL lat_d2_beat: got %h last=%b want 00000055 last=1", dat2, last2);
    end
    total++; if (done_cyc !== 4) begin bad++; $display("FAIL lat_done_cyc: got %0d want 4", done_cyc); end
    idle(4, act);
  endtask

  task automatic test_len_zero();
    int act;
    run_xfer(10'h040, 11'd0, 1, -1, 10);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL len0_done_cyc: got %0d want 1", done_cyc); end
    total++; if (re_cnt !== 0 || fv !== -1 || beats.size() !== 0) begin
      bad++; $display("FAIL len0_activity: got re=%0d first_valid=%0d beats=%0d want 0/-1/0", re_cnt, fv, beats.size());
    end
    total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b want 0", done_busy); end
    idle(3, act);
    total++; if (act !== 0) begin bad++; $display("FAIL len0_quiet: got %0d active cycles want 0", act); end
  endtask

  task automatic test_start_busy();
    int act;
    run_xfer(10'h020, 11'd4, 1, 2, 40);
    total++; if (re_cnt !== 4 || addr_ok !== 1'b1) begin
      bad++; $display("FAIL busy_start_issue: got cnt=%0d ok=%b want cnt=4 ok=1", re_cnt, addr_ok);
    end
    total++; if (beats.size() !== 4) begin bad++; $display("FAIL busy_start_beats: got %0d want 4", beats.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] a;
      a = 10'h020 + 10'(i);
      total++;
      if (i >= beats.size()) begin bad++; $display("FAIL busy_start_beat%0d: got none want %h", i, {22'b0, a}); end
      else if (beats[i] !== {22'b0, a}) begin
        bad++; $display("FAIL busy_start_beat%0d: got %h want %h", i, beats[i], {22'b0, a});
      end
    end
    idle(6, act);
    total++; if (act !== 0) begin bad++; $display("FAIL busy_start_quiet: got %0d active cycles want 0", act); end
  endtask

  task automatic test_reset_mid();
    int popped, act;
    logic hit;
    popped = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 10'h080; start_len = 11'd8; m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready) popped++;
      if (popped == 3) begin rst = 1'b1; hit = 1'b1; break; end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_timeout: got %0d beats want 3", popped); end
    @(negedge clk);
    total++;
    if ({busy, done, mem_re, m_valid, m_last} !== 5'b0 || mem_addr !== 10'h0 || m_data !== 32'h0) begin
      bad++; $display("FAIL rstmid_outputs: got ctrl=%b addr=%h data=%h want 0", {busy, done, mem_re, m_valid, m_last}, mem_addr, m_data);
    end
    rst = 1'b0;
    idle(2, act);
    total++; if (act !== 0) begin bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", act); end
    run_xfer(10'h080, 11'd8, 1, -1, 40);
    total++; if (beats.size() !== 8) begin bad++; $display("FAIL rstmid_beat_cnt: got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'h080 + 10'(i);
      total++;
      if (i >= beats.size()) begin bad++; $display("FAIL rstmid_beat%0d: got none want %h", i, {22'b0, a}); end
      else if (beats[i] !== {22'b0, a} || lasts[i] !== (i == 7)) begin
        bad++; $display("FAIL rstmid_beat%0d: got %h last=%b want %h last=%b", i, beats[i], lasts[i], {22'b0, a}, i == 7);
      end
    end
    total++; if (done_cyc !== 11) begin bad++; $display("FAIL rstmid_done_cyc: got %0d want 11", done_cyc); end
    idle(4, act);
  endtask

`ifdef MEM_RD_STREAMER_ABORT_EN
  task automatic test_abort();
    int popped, act;
    logic hit;
    popped = 0; hit = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = 10'h0C0; start_len = 11'd8; m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready) popped++;
      if (popped == 3) begin abort = 1'b1; hit = 1'b1; break; end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL abort_timeout: got %0d beats want 3", popped); end
    @(negedge clk);
    abort = 1'b0;
    total++; if ({m_valid, done, busy, mem_re} !== 4'b0100) begin
      bad++; $display("FAIL abort_response: got valid/done/busy/re=%b want 0100", {m_valid, done, busy, mem_re});
    end
    idle(5, act);
    total++; if (act !== 0) begin bad++; $display("FAIL abort_stale: got %0d active cycles want 0", act); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b1;
`ifdef MEM_RD_STREAMER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_latency();
    test_len_zero();
    test_start_busy();
    test_reset_mid();
`ifdef MEM_RD_STREAMER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
